// File: rtl/sdram_init_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_init_pkg
// Description : SDRAM init sequencer widths, command encodings, FSM states
// Revision    : 1.0
// ============================================================================
package sdram_init_pkg;

  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;
  localparam int DQM_W  = 2;
  localparam int CMD_W  = 4;

  // Encoded as {CSn, RASn, CASn, WEn}
  localparam logic [CMD_W-1:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_REFRESH   = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_LOAD_MODE = 4'b0000;

  // ADDR[10] selects "all banks" for PRECHARGE
  localparam logic [ADDR_W-1:0] ADDR_PRECHARGE_ALL = 13'h0400;

  typedef enum logic [3:0] {
    ST_POWERUP   = 4'd0,
    ST_CKE_NOP   = 4'd1,
    ST_PRECHARGE = 4'd2,
    ST_WAIT_RP   = 4'd3,
    ST_REFRESH   = 4'd4,
    ST_WAIT_RFC  = 4'd5,
    ST_LOAD_MODE = 4'd6,
    ST_WAIT_MRD  = 4'd7,
    ST_DONE      = 4'd8
  } init_state_e;

  typedef struct packed {
    logic              cke;
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [BA_W-1:0]   ba;
  } init_pins_t;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_init_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_init_sequencer_if
// Description : SDR SDRAM pin bundle; master drives commands, slave returns DQ
// Revision    : 1.0
// ============================================================================
interface sdram_init_sequencer_if;
  import sdram_init_pkg::*;

  logic [ADDR_W-1:0] ADDR;
  logic [BA_W-1:0]   BA;
  logic [DQM_W-1:0]  DQM;
  logic              CKE;
  logic              CSn;
  logic              RASn;
  logic              CASn;
  logic              WEn;
  logic [DQ_W-1:0]   DQ_write;
  logic              DQ_writeEnable;
  logic [DQ_W-1:0]   DQ_read;

  modport master (
    output ADDR, BA, DQM, CKE, CSn, RASn, CASn, WEn, DQ_write, DQ_writeEnable,
    input  DQ_read
  );

  modport slave (
    input  ADDR, BA, DQM, CKE, CSn, RASn, CASn, WEn, DQ_write, DQ_writeEnable,
    output DQ_read
  );

endinterface
`default_nettype wire

// File: rtl/sdram_delay_counter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_delay_counter
// Description : Loadable saturating down-counter with zero flag
// Revision    : 1.0
// ============================================================================
module sdram_delay_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_value,
  output logic                  zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Holds at zero rather than wrapping so a stale wait can never re-arm
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sdram_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sdram_init_sequencer
// Description : SDR SDRAM power-up init, then permanent controller pass-through
// Revision    : 1.0
// ============================================================================
module sdram_init_sequencer
  import sdram_init_pkg::*;
#(
  parameter int                T_POWERUP     = 13334,
  parameter int                T_RP          = 3,
  parameter int                T_RFC         = 9,
  parameter int                T_MRD         = 2,
  parameter int                REFRESH_COUNT = 2,
  parameter logic [ADDR_W-1:0] MODE_VALUE    = 13'h030
) (
  input  wire logic             io_axiClk,
  input  wire logic             io_asyncResetn,
  sdram_init_sequencer_if.slave  io_ctrl,
  sdram_init_sequencer_if.master io_sdram,
  output logic                  io_done
);

  localparam int T_MAX  = max_of4(T_POWERUP, T_RP, T_RFC, T_MRD);
  localparam int WAIT_W = $clog2(T_MAX) + 1;
  localparam int REF_W  = $clog2(REFRESH_COUNT) + 1;

  localparam logic [WAIT_W-1:0] LD_POWERUP = WAIT_W'(T_POWERUP);
  localparam logic [WAIT_W-1:0] LD_RP      = WAIT_W'(T_RP - 1);
  localparam logic [WAIT_W-1:0] LD_RFC     = WAIT_W'(T_RFC - 1);
  localparam logic [WAIT_W-1:0] LD_MRD     = WAIT_W'(T_MRD - 1);
  localparam logic [REF_W-1:0]  REF_INIT   = REF_W'(REFRESH_COUNT - 1);

  localparam init_pins_t PINS_RESET = '{cke: 1'b0, cmd: CMD_INHIBIT, addr: '0, ba: '0};

  init_state_e       state_q, state_d;
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  init_pins_t        pins_q, pins_d;
  logic              done_q, done_d;
  logic              wait_load;
  logic [WAIT_W-1:0] wait_value;
  logic              wait_zero;

  // Counter is loaded on entry to each command state with T_x-1, so a command
  // state that already sees zero skips its WAIT_* state entirely.
  sdram_delay_counter #(
    .WIDTH       (WAIT_W),
    .RESET_VALUE (LD_POWERUP)
  ) u_delay (
    .clk        (io_axiClk),
    .rst_n      (io_asyncResetn),
    .load       (wait_load),
    .load_value (wait_value),
    .zero       (wait_zero)
  );

  always_comb begin
    state_d    = state_q;
    ref_cnt_d  = ref_cnt_q;
    wait_load  = 1'b0;
    wait_value = '0;
    case (state_q)
      ST_POWERUP: begin
        if (wait_zero) state_d = ST_CKE_NOP;
      end
      ST_CKE_NOP: begin
        state_d    = ST_PRECHARGE;
        wait_load  = 1'b1;
        wait_value = LD_RP;
      end
      ST_PRECHARGE, ST_WAIT_RP: begin
        if (wait_zero) begin
          state_d    = ST_REFRESH;
          wait_load  = 1'b1;
          wait_value = LD_RFC;
        end else begin
          state_d = ST_WAIT_RP;
        end
      end
      ST_REFRESH, ST_WAIT_RFC: begin
        if (!wait_zero) begin
          state_d = ST_WAIT_RFC;
        end else if (ref_cnt_q != '0) begin
          state_d    = ST_REFRESH;
          ref_cnt_d  = ref_cnt_q - 1'b1;
          wait_load  = 1'b1;
          wait_value = LD_RFC;
        end else begin
          state_d    = ST_LOAD_MODE;
          wait_load  = 1'b1;
          wait_value = LD_MRD;
        end
      end
      ST_LOAD_MODE, ST_WAIT_MRD: begin
        state_d = wait_zero ? ST_DONE : ST_WAIT_MRD;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_POWERUP;
      end
    endcase
  end

  // Pins are decoded from the next state so they update on the same edge
  always_comb begin
    pins_d = '{cke: 1'b1, cmd: CMD_NOP, addr: '0, ba: '0};
    case (state_d)
      ST_POWERUP: begin
        pins_d = PINS_RESET;
      end
      ST_PRECHARGE: begin
        pins_d.cmd  = CMD_PRECHARGE;
        pins_d.addr = ADDR_PRECHARGE_ALL;
      end
      ST_REFRESH: begin
        pins_d.cmd = CMD_REFRESH;
      end
      ST_LOAD_MODE: begin
        pins_d.cmd  = CMD_LOAD_MODE;
        pins_d.addr = MODE_VALUE;
      end
      default: begin
        pins_d.cmd = CMD_NOP;
      end
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q   <= ST_POWERUP;
      ref_cnt_q <= REF_INIT;
      pins_q    <= PINS_RESET;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_cnt_q <= ref_cnt_d;
      pins_q    <= pins_d;
      done_q    <= done_d;
    end
  end

  assign io_done = done_q;

  assign io_sdram.CKE            = done_q ? io_ctrl.CKE  : pins_q.cke;
  assign io_sdram.CSn            = done_q ? io_ctrl.CSn  : pins_q.cmd[3];
  assign io_sdram.RASn           = done_q ? io_ctrl.RASn : pins_q.cmd[2];
  assign io_sdram.CASn           = done_q ? io_ctrl.CASn : pins_q.cmd[1];
  assign io_sdram.WEn            = done_q ? io_ctrl.WEn  : pins_q.cmd[0];
  assign io_sdram.ADDR           = done_q ? io_ctrl.ADDR : pins_q.addr;
  assign io_sdram.BA             = done_q ? io_ctrl.BA   : pins_q.ba;
  assign io_sdram.DQM            = done_q ? io_ctrl.DQM  : {DQM_W{1'b1}};
  assign io_sdram.DQ_write       = io_ctrl.DQ_write;
  assign io_sdram.DQ_writeEnable = io_ctrl.DQ_writeEnable & done_q;
  assign io_ctrl.DQ_read         = io_sdram.DQ_read;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_init_sequencer
// Description : Scoreboard bench for two sequencer configurations vs timing model
// Revision    : 1.0
// ============================================================================
module tb_sdram_init_sequencer;
  import sdram_init_pkg::*;

  localparam int TP    = 20;
  localparam int A_RP  = 3, A_RFC = 9, A_RC = 2, A_MRD = 2;
  localparam int B_RP  = 1, B_RFC = 9, B_RC = 1, B_MRD = 2;

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    logic        dq_we;
    logic        done;
    logic [15:0] dq_write;
    logic [15:0] dq_read;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done_a, done_b;
  always #5 clk = ~clk;

  sdram_init_sequencer_if ctrl_a ();
  sdram_init_sequencer_if sdram_a ();
  sdram_init_sequencer_if ctrl_b ();
  sdram_init_sequencer_if sdram_b ();

  sdram_init_sequencer #(
    .T_POWERUP(TP), .T_RP(A_RP), .T_RFC(A_RFC), .T_MRD(A_MRD),
    .REFRESH_COUNT(A_RC), .MODE_VALUE(13'h030)
  ) dut_a (
    .io_axiClk(clk), .io_asyncResetn(rst_n),
    .io_ctrl(ctrl_a.slave), .io_sdram(sdram_a.master), .io_done(done_a)
  );

  sdram_init_sequencer #(
    .T_POWERUP(TP), .T_RP(B_RP), .T_RFC(B_RFC), .T_MRD(B_MRD),
    .REFRESH_COUNT(B_RC), .MODE_VALUE(13'h030)
  ) dut_b (
    .io_axiClk(clk), .io_asyncResetn(rst_n),
    .io_ctrl(ctrl_b.slave), .io_sdram(sdram_b.master), .io_done(done_b)
  );

  obs_t q_a[$], q_b[$];
  int   qk_a[$], qk_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;

  logic        c_cke, c_we;
  logic [3:0]  c_cmd;
  logic [12:0] c_addr;
  logic [1:0]  c_ba, c_dqm;
  logic [15:0] c_dqw, c_dqr;

  // Expected pins after edge k, straight from the published command timeline
  function automatic obs_t model(input int kk, input int trp, input int trfc,
                                 input int rc, input int tmrd);
    obs_t e;
    int p, lm, de;
    p  = TP + 2;
    lm = p + trp + rc * trfc;
    de = lm + tmrd;
    e = '{cke: 1'b1, cmd: 4'b0111, addr: 13'h0, ba: 2'b00, dqm: 2'b11,
          dq_we: 1'b0, done: 1'b0, dq_write: c_dqw, dq_read: c_dqr};
    if (kk == 0 || kk <= TP) begin
      e.cke = 1'b0;
      e.cmd = 4'b1111;
    end else if (kk >= de) begin
      e.cke = c_cke; e.cmd = c_cmd; e.addr = c_addr; e.ba = c_ba;
      e.dqm = c_dqm; e.dq_we = c_we; e.done = 1'b1;
    end else if (kk == p) begin
      e.cmd  = 4'b0010;
      e.addr = 13'h400;
    end else if (kk >= p + trp && kk < lm && ((kk - p - trp) % trfc) == 0) begin
      e.cmd = 4'b0001;
    end else if (kk == lm) begin
      e.cmd  = 4'b0000;
      e.addr = 13'h030;
    end
    return e;
  endfunction

  task automatic drive_random();
    c_cke  = 1'($urandom);
    c_cmd  = 4'($urandom);
    c_addr = 13'($urandom);
    c_ba   = 2'($urandom);
    c_dqm  = 2'($urandom);
    c_we   = 1'($urandom);
    c_dqw  = 16'($urandom);
    c_dqr  = 16'($urandom);
    {ctrl_a.CSn, ctrl_a.RASn, ctrl_a.CASn, ctrl_a.WEn} = c_cmd;
    {ctrl_b.CSn, ctrl_b.RASn, ctrl_b.CASn, ctrl_b.WEn} = c_cmd;
    ctrl_a.CKE = c_cke;   ctrl_b.CKE = c_cke;
    ctrl_a.ADDR = c_addr; ctrl_b.ADDR = c_addr;
    ctrl_a.BA = c_ba;     ctrl_b.BA = c_ba;
    ctrl_a.DQM = c_dqm;   ctrl_b.DQM = c_dqm;
    ctrl_a.DQ_writeEnable = c_we; ctrl_b.DQ_writeEnable = c_we;
    ctrl_a.DQ_write = c_dqw;      ctrl_b.DQ_write = c_dqw;
    sdram_a.DQ_read = c_dqr;      sdram_b.DQ_read = c_dqr;
  endtask

  // One cycle: advance edge index, apply reset level and new inputs, post expectations
  task automatic step(input logic rst_val);
    @(posedge clk);
    if (rst_n) k++;
    #1;
    rst_n = rst_val;
    if (!rst_n) k = 0;
    drive_random();
    q_a.push_back(model(k, A_RP, A_RFC, A_RC, A_MRD)); qk_a.push_back(k);
    q_b.push_back(model(k, B_RP, B_RFC, B_RC, B_MRD)); qk_b.push_back(k);
  endtask

  task automatic check(input string name, input int kk, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%h required=%h", name, kk, act, exp);
    end
  endtask

  initial begin
    obs_t act;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        act = '{cke: sdram_a.CKE, cmd: {sdram_a.CSn, sdram_a.RASn, sdram_a.CASn, sdram_a.WEn},
                addr: sdram_a.ADDR, ba: sdram_a.BA, dqm: sdram_a.DQM,
                dq_we: sdram_a.DQ_writeEnable, done: done_a,
                dq_write: sdram_a.DQ_write, dq_read: ctrl_a.DQ_read};
        check("cfg_a_pins", qk_a.pop_front(), act, q_a.pop_front());
      end
      if (q_b.size() > 0) begin
        act = '{cke: sdram_b.CKE, cmd: {sdram_b.CSn, sdram_b.RASn, sdram_b.CASn, sdram_b.WEn},
                addr: sdram_b.ADDR, ba: sdram_b.BA, dqm: sdram_b.DQM,
                dq_we: sdram_b.DQ_writeEnable, done: done_b,
                dq_write: sdram_b.DQ_write, dq_read: ctrl_b.DQ_read};
        check("cfg_b_pins", qk_b.pop_front(), act, q_b.pop_front());
      end
    end
  end

  initial begin
    drive_random();
    repeat (3)  step(1'b0);
    repeat (60) step(1'b1);
    repeat (2)  step(1'b0);
    // Release, run to edge 29, then the next step lands edge 30 and asserts reset
    repeat (30) step(1'b1);
    repeat (3)  step(1'b0);
    repeat (60) step(1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
